// File: rtl/data_mem_responder.sv
// data_mem_responder: memory-side responder for the core's data-memory port.
// Byte-lane word RAM, a post-reset clear engine, a misalignment trap and a small
// MMIO counter bank.
//
// Ports:
//   clk          clock, all state updates on posedge
//   reset        synchronous active-high reset
//   Addr         byte address from the core
//   MemWrite     store request this cycle
//   WriteData    right-aligned store data
//   DataType     load extension, 0 = sign, 1 = zero
//   DataSize     00 byte, 01 half, 10 word, 11 illegal
//   ReadData     combinational load data
//   InitDone     RAM clear finished
//   MisalignErr  sticky misaligned/illegal access flag
//
// There is no load strobe on this interface, so every RUN cycle without MemWrite
// is treated as a load and is subject to the alignment rules.
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_FF00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Addr,
    input  logic        MemWrite,
    input  logic [31:0] WriteData,
    input  logic        DataType,
    input  logic [1:0]  DataSize,
    output logic [31:0] ReadData,
    output logic        InitDone,
    output logic        MisalignErr
);

    localparam int unsigned AW  = $clog2(DEPTH_WORDS);
    localparam int unsigned DW  = 32;
    localparam int unsigned EW  = 16;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [3:0] OFF_CYCLE  = 4'd0;
    localparam logic [3:0] OFF_STORE  = 4'd1;
    localparam logic [3:0] OFF_STATUS = 4'd2;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   ptr_q, ptr_d;
    logic            init_done_q, init_done_d;
    logic            misalign_err_q, misalign_err_d;
    logic [DW-1:0]   cycle_cnt_q, cycle_cnt_d;
    logic [DW-1:0]   store_cnt_q, store_cnt_d;
    logic [EW-1:0]   err_cnt_q, err_cnt_d;

    logic [DW-1:0]   mem_q [DEPTH_WORDS];

    logic            mem_we;
    logic [3:0]      mem_be;
    logic [AW-1:0]   mem_idx;
    logic [DW-1:0]   mem_wdata;

    logic            is_mmio;
    logic [3:0]      mmio_off;
    logic [AW-1:0]   word_idx;
    logic            illegal;

    // Address decode and alignment check
    always_comb begin
        is_mmio  = (Addr[31:6] == MMIO_BASE[31:6]);
        mmio_off = Addr[5:2];
        word_idx = Addr[AW+1:2];
        illegal  = 1'b0;
        case (DataSize)
            SZ_BYTE: illegal = is_mmio;
            SZ_HALF: illegal = Addr[0] | is_mmio;
            SZ_WORD: illegal = (Addr[1:0] != 2'b00);
            default: illegal = 1'b1;
        endcase
    end

    // Next-state: clear engine, store path, counters and error flags
    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        init_done_d    = init_done_q;
        misalign_err_d = misalign_err_q;
        cycle_cnt_d    = cycle_cnt_q;
        store_cnt_d    = store_cnt_q;
        err_cnt_d      = err_cnt_q;
        mem_we         = 1'b0;
        mem_be         = 4'b0000;
        mem_idx        = word_idx;
        mem_wdata      = '0;

        case (state_q)
            S_CLEAR: begin
                mem_we    = 1'b1;
                mem_be    = 4'b1111;
                mem_idx   = ptr_q;
                ptr_d     = ptr_q + AW'(1);
                if (ptr_q == AW'(DEPTH_WORDS - 1)) begin
                    state_d     = S_RUN;
                    init_done_d = 1'b1;
                end
            end
            S_RUN: begin
                cycle_cnt_d = cycle_cnt_q + 32'd1;
                // An access is either illegal or a legal store, never both, so the
                // status clear and a new error cannot collide in one cycle.
                if (illegal) begin
                    misalign_err_d = 1'b1;
                    if (err_cnt_q != {EW{1'b1}}) begin
                        err_cnt_d = err_cnt_q + 16'd1;
                    end
                end else if (MemWrite) begin
                    if (is_mmio) begin
                        if (mmio_off == OFF_STATUS) begin
                            misalign_err_d = 1'b0;
                            err_cnt_d      = '0;
                        end
                    end else begin
                        mem_we      = 1'b1;
                        store_cnt_d = store_cnt_q + 32'd1;
                        case (DataSize)
                            SZ_BYTE: begin
                                mem_be    = 4'b0001 << Addr[1:0];
                                mem_wdata = {4{WriteData[7:0]}};
                            end
                            SZ_HALF: begin
                                mem_be    = Addr[1] ? 4'b1100 : 4'b0011;
                                mem_wdata = {2{WriteData[15:0]}};
                            end
                            default: begin
                                mem_be    = 4'b1111;
                                mem_wdata = WriteData;
                            end
                        endcase
                    end
                end
            end
            default: begin
                state_d = S_CLEAR;
            end
        endcase
    end

    // State and counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_CLEAR;
            ptr_q          <= '0;
            init_done_q    <= 1'b0;
            misalign_err_q <= 1'b0;
            cycle_cnt_q    <= '0;
            store_cnt_q    <= '0;
            err_cnt_q      <= '0;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            init_done_q    <= init_done_d;
            misalign_err_q <= misalign_err_d;
            cycle_cnt_q    <= cycle_cnt_d;
            store_cnt_q    <= store_cnt_d;
            err_cnt_q      <= err_cnt_d;
        end
    end

    // Byte-lane RAM; contents are zeroed by the clear engine rather than by reset
    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_be[i]) begin
                    mem_q[mem_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
                end
            end
        end
    end

    // Combinational load path; a same-cycle store is not yet visible here
    logic [DW-1:0] rd_word;
    logic [7:0]    rd_byte;
    logic [15:0]   rd_half;

    always_comb begin
        rd_word  = mem_q[word_idx];
        rd_byte  = rd_word[{Addr[1:0], 3'b000} +: 8];
        rd_half  = rd_word[{Addr[1], 4'b0000} +: 16];
        ReadData = '0;
        if ((state_q == S_RUN) && !illegal) begin
            if (is_mmio) begin
                case (mmio_off)
                    OFF_CYCLE:  ReadData = cycle_cnt_q;
                    OFF_STORE:  ReadData = store_cnt_q;
                    OFF_STATUS: ReadData = {err_cnt_q, 15'b0, misalign_err_q};
                    default:    ReadData = '0;
                endcase
            end else begin
                case (DataSize)
                    SZ_BYTE: ReadData = DataType ? {24'b0, rd_byte}
                                                 : {{24{rd_byte[7]}}, rd_byte};
                    SZ_HALF: ReadData = DataType ? {16'b0, rd_half}
                                                 : {{16{rd_half[15]}}, rd_half};
                    default: ReadData = rd_word;
                endcase
            end
        end
    end

    assign InitDone    = init_done_q;
    assign MisalignErr = misalign_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed steps followed by random
// traffic, each cycle compared against a byte-array reference model.
module tb_data_mem_responder;

    localparam int unsigned DEPTH     = 256;
    localparam logic [31:0] MMIO_BASE = 32'hFFFF_FF00;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Addr;
    logic        MemWrite;
    logic [31:0] WriteData;
    logic        DataType;
    logic [1:0]  DataSize;
    logic [31:0] ReadData;
    logic        InitDone;
    logic        MisalignErr;

    int n_chk  = 0;
    int n_fail = 0;

    data_mem_responder #(
        .DEPTH_WORDS (DEPTH),
        .MMIO_BASE   (MMIO_BASE)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .Addr        (Addr),
        .MemWrite    (MemWrite),
        .WriteData   (WriteData),
        .DataType    (DataType),
        .DataSize    (DataSize),
        .ReadData    (ReadData),
        .InitDone    (InitDone),
        .MisalignErr (MisalignErr)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [7:0]  m_mem [DEPTH*4];
    bit          m_run;
    int          m_clr;
    bit          m_mis;
    int          m_err;
    logic [31:0] m_cyc;
    logic [31:0] m_st;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit m_is_mmio(input logic [31:0] a);
        return (a >> 6) == (MMIO_BASE >> 6);
    endfunction

    function automatic bit m_illegal(input logic [31:0] a, input logic [1:0] ds);
        if (ds == 2'd3) return 1'b1;
        if (ds == 2'd1 && (a % 2) != 0) return 1'b1;
        if (ds == 2'd2 && (a % 4) != 0) return 1'b1;
        if (m_is_mmio(a) && ds != 2'd2) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a, input logic dt,
                                           input logic [1:0] ds);
        longint unsigned v;
        int base;
        int n;
        if (!m_run || m_illegal(a, ds)) return 32'h0;
        if (m_is_mmio(a)) begin
            case (a % 64)
                0:       return m_cyc;
                4:       return m_st;
                8:       return (32'(m_err) << 16) | 32'(m_mis);
                default: return 32'h0;
            endcase
        end
        base = int'(a % (DEPTH * 4));
        n    = 1 << ds;
        v    = 0;
        for (int i = 0; i < n; i++) v = v | (longint'(m_mem[base+i]) << (8 * i));
        if (n < 4 && !dt && ((v >> (8 * n - 1)) & 1) == 1)
            v = v + (64'h1_0000_0000 - (64'd1 << (8 * n)));
        return 32'(v);
    endfunction

    task automatic m_reset();
        m_run = 0; m_clr = 0; m_mis = 0; m_err = 0; m_cyc = 0; m_st = 0;
    endtask

    // Apply one clock edge to the model with the inputs currently driven
    task automatic m_commit();
        int base;
        if (reset) begin
            m_reset();
        end else if (!m_run) begin
            for (int i = 0; i < 4; i++) m_mem[m_clr*4+i] = 8'h00;
            m_clr++;
            if (m_clr == DEPTH) m_run = 1;
        end else begin
            m_cyc = m_cyc + 1;
            if (m_illegal(Addr, DataSize)) begin
                m_mis = 1;
                if (m_err < 65535) m_err++;
            end else if (MemWrite) begin
                if (m_is_mmio(Addr)) begin
                    if (Addr % 64 == 8) begin m_mis = 0; m_err = 0; end
                end else begin
                    base = int'(Addr % (DEPTH * 4));
                    for (int i = 0; i < (1 << DataSize); i++)
                        m_mem[base+i] = 8'(WriteData >> (8 * i));
                    m_st = m_st + 1;
                end
            end
        end
    endtask

    // One clock cycle: drive, check outputs against model, advance model
    task automatic cyc(input logic [31:0] a, input logic we, input logic [31:0] wd,
                       input logic dt, input logic [1:0] ds, output logic [31:0] rd);
        Addr = a; MemWrite = we; WriteData = wd; DataType = dt; DataSize = ds;
        #1;
        rd = ReadData;
        chk("read_data", ReadData, m_read(a, dt, ds));
        chk("init_done", 32'(InitDone), 32'(m_run));
        chk("misalign_err", 32'(MisalignErr), 32'(m_mis));
        @(posedge clk);
        m_commit();
        @(negedge clk);
    endtask

    task automatic idle();
        logic [31:0] rd;
        cyc(32'h0, 1'b0, 32'h0, 1'b0, 2'd2, rd);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        idle();
        reset = 1'b0;
    endtask

    task automatic wait_init(input string tag);
        int n = 0;
        while (!InitDone && n < 400) begin
            idle();
            n++;
        end
        chk(tag, 32'(n), 32'd256);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] c0;
        logic [31:0] a;
        logic [1:0]  ds;

        reset = 1'b1; Addr = 32'h0; MemWrite = 1'b0; WriteData = 32'h0;
        DataType = 1'b0; DataSize = 2'd2;
        repeat (2) @(posedge clk);
        m_reset();
        @(negedge clk);
        chk("reset_init_done", 32'(InitDone), 32'd0);
        chk("reset_misalign", 32'(MisalignErr), 32'd0);
        reset = 1'b0;

        // 1: clear latency and zeroed RAM
        wait_init("init_latency");
        cyc(32'h0000_0100, 1'b0, 32'h0, 1'b0, 2'd2, rd);
        chk("cleared_word", rd, 32'h0);
        cyc(32'h0000_03FC, 1'b0, 32'h0, 1'b0, 2'd2, rd);
        chk("cleared_last_word", rd, 32'h0);

        // 2: byte stores use WriteData[7:0] only; sign/zero extension
        cyc(32'h34, 1'b1, 32'h0008_0000, 1'b0, 2'd0, rd);
        cyc(32'h34, 1'b0, 32'h0, 1'b1, 2'd0, rd);
        chk("lbu_low_byte_only", rd, 32'h0);
        cyc(32'h34, 1'b1, 32'h0000_0080, 1'b0, 2'd0, rd);
        cyc(32'h34, 1'b0, 32'h0, 1'b1, 2'd0, rd);
        chk("lbu_0x80", rd, 32'h0000_0080);
        cyc(32'h34, 1'b0, 32'h0, 1'b0, 2'd0, rd);
        chk("lb_0x80", rd, 32'hFFFF_FF80);

        // 3: word store, lane selection, read-during-write returns old data
        cyc(32'h40, 1'b1, 32'h1122_3344, 1'b0, 2'd2, rd);
        chk("rdw_old_data", rd, 32'h0);
        cyc(32'h42, 1'b0, 32'h0, 1'b1, 2'd1, rd);
        chk("lh_upper_half", rd, 32'h0000_1122);
        cyc(32'h43, 1'b0, 32'h0, 1'b1, 2'd0, rd);
        chk("lbu_lane3", rd, 32'h0000_0011);
        cyc(32'h0000_0440, 1'b0, 32'h0, 1'b0, 2'd2, rd);
        chk("alias_word", rd, 32'h1122_3344);

        // 4: misaligned store, status read and clear, read-only MMIO
        cyc(32'h41, 1'b1, 32'hDEAD_BEEF, 1'b0, 2'd2, rd);
        cyc(32'h40, 1'b0, 32'h0, 1'b0, 2'd2, rd);
        chk("misaligned_no_write", rd, 32'h1122_3344);
        chk("misalign_set", 32'(MisalignErr), 32'd1);
        cyc(MMIO_BASE + 32'h8, 1'b0, 32'h0, 1'b0, 2'd2, rd);
        chk("status_one_err", rd, 32'h0001_0001);
        cyc(MMIO_BASE + 32'h8, 1'b1, 32'h0, 1'b0, 2'd2, rd);
        cyc(MMIO_BASE + 32'h8, 1'b0, 32'h0, 1'b0, 2'd2, rd);
        chk("status_cleared", rd, 32'h0);
        cyc(MMIO_BASE + 32'h0, 1'b1, 32'h5, 1'b0, 2'd2, rd);
        cyc(MMIO_BASE + 32'hC, 1'b0, 32'h0, 1'b0, 2'd2, rd);
        chk("mmio_unmapped", rd, 32'h0);
        chk("ro_store_no_err", 32'(MisalignErr), 32'd0);
        cyc(MMIO_BASE + 32'h8, 1'b0, 32'h0, 1'b1, 2'd0, rd);
        chk("mmio_byte_illegal", rd, 32'h0);
        cyc(32'h44, 1'b0, 32'h0, 1'b0, 2'd3, rd);
        chk("size3_illegal", rd, 32'h0);
        cyc(MMIO_BASE + 32'h8, 1'b0, 32'h0, 1'b0, 2'd2, rd);
        chk("status_two_errs", rd, 32'h0002_0001);

        // 5: store counter and cycle counter after a fresh reset
        pulse_reset();
        wait_init("init_latency_2");
        cyc(32'h10, 1'b1, 32'hA5A5_A5A5, 1'b0, 2'd2, rd);
        cyc(32'h16, 1'b1, 32'h0000_BEEF, 1'b0, 2'd1, rd);
        cyc(32'h1B, 1'b1, 32'h0000_0077, 1'b0, 2'd0, rd);
        cyc(MMIO_BASE + 32'h4, 1'b0, 32'h0, 1'b0, 2'd2, rd);
        chk("store_cnt_3", rd, 32'd3);
        cyc(MMIO_BASE + 32'h0, 1'b0, 32'h0, 1'b0, 2'd2, c0);
        idle();
        cyc(MMIO_BASE + 32'h0, 1'b0, 32'h0, 1'b0, 2'd2, rd);
        chk("cycle_cnt_delta", rd - c0, 32'd2);

        // 6: reset in the middle of the clear restarts the full sweep
        pulse_reset();
        repeat (100) idle();
        chk("mid_clear_not_done", 32'(InitDone), 32'd0);
        pulse_reset();
        wait_init("init_latency_restart");
        cyc(32'h10, 1'b0, 32'h0, 1'b0, 2'd2, rd);
        chk("restart_cleared", rd, 32'h0);

        // Random traffic against the reference model
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 799) == 0) begin
                pulse_reset();
            end else begin
                if ($urandom_range(0, 9) < 2)
                    a = MMIO_BASE + 32'($urandom_range(0, 63));
                else
                    a = ($urandom & 32'h7FFF_FC00) | 32'($urandom_range(0, 1023));
                ds = ($urandom_range(0, 19) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
                if ($urandom_range(0, 9) < 8) a = a & ~((32'd1 << ds) - 32'd1);
                cyc(a, ($urandom_range(0, 2) == 0), $urandom, 1'($urandom_range(0, 1)), ds, rd);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
